// File: rtl/mem_sys_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_sys_arbiter
// Purpose  : Two-port round-robin arbiter and access sequencer in front of the
//            single-port byte-write memory system. A granted request is
//            checked for func3 legality and alignment. A legal one is issued
//            as one memory access (IDLE -> ISSUE [-> RESP]). An illegal one is
//            acked and then reported with a one-cycle err pulse.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            pN_req/store/func3/addr/wdata - requester N payload (N = 0, 1)
//            pN_ack/rvalid/rdata/err       - requester N handshake/result
//            mem_ena/store/func3/addr/wdata - memory-system command port
//            mem_load_data                  - receiver output (load word)
// Revision : 1.0 - initial release
// ============================================================================
module mem_sys_arbiter #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_store,
    input  logic [2:0]        p0_func3,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_ack,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_store,
    input  logic [2:0]        p1_func3,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_ack,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              p1_err,
    output logic              mem_ena,
    output logic              mem_store,
    output logic [2:0]        mem_func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_load_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]        r_state;
    logic              r_ptr;      // port favoured on the next contended grant
    logic              r_owner;    // port that owns the access in flight
    logic              r_store;
    logic [2:0]        r_func3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_err0;
    logic              r_err1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [31:0]       r_rdata0;
    logic [31:0]       r_rdata1;

    logic              w_idle;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_sel_store;
    logic [2:0]        w_sel_func3;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [31:0]       w_sel_wdata;
    logic              w_f3_ok;
    logic              w_align_ok;
    logic              w_legal;

    // Grants happen only in IDLE; with both requesting, the pointer decides.
    assign w_idle = (r_state == S_IDLE);
    assign w_gnt0 = w_idle & p0_req & (~p1_req | ~r_ptr);
    assign w_gnt1 = w_idle & p1_req & (~p0_req |  r_ptr);

    assign w_sel_store = w_gnt1 ? p1_store : p0_store;
    assign w_sel_func3 = w_gnt1 ? p1_func3 : p0_func3;
    assign w_sel_addr  = w_gnt1 ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_gnt1 ? p1_wdata : p0_wdata;

    always_comb begin
        w_f3_ok = 1'b0;
        case (w_sel_func3)
            3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
            3'b100, 3'b101:         w_f3_ok = ~w_sel_store;  // unsigned forms are load-only
            default:                w_f3_ok = 1'b0;
        endcase
        w_align_ok = 1'b1;
        case (w_sel_func3[1:0])
            2'b01:   w_align_ok = ~w_sel_addr[0];
            2'b10:   w_align_ok = (w_sel_addr[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
    end

    assign w_legal = w_f3_ok & w_align_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= 1'b0;
            r_owner   <= 1'b0;
            r_store   <= 1'b0;
            r_func3   <= 3'b000;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= 32'd0;
            r_rdata1  <= 32'd0;
        end else begin
            r_err0    <= w_gnt0 & ~w_legal;
            r_err1    <= w_gnt1 & ~w_legal;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        // Pointer flips on every grant, rejected ones included.
                        r_ptr <= w_gnt0;
                        if (w_legal) begin
                            r_owner <= w_gnt1;
                            r_store <= w_sel_store;
                            r_func3 <= w_sel_func3;
                            r_addr  <= w_sel_addr;
                            r_wdata <= w_sel_wdata;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= r_store ? S_IDLE : S_RESP;
                end
                S_RESP: begin
                    // func3/addr are still held, so the receiver output is valid now.
                    if (r_owner) begin
                        r_rdata1  <= mem_load_data;
                        r_rvalid1 <= 1'b1;
                    end else begin
                        r_rdata0  <= mem_load_data;
                        r_rvalid0 <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign p0_ack    = w_gnt0;
    assign p1_ack    = w_gnt1;
    assign p0_err    = r_err0;
    assign p1_err    = r_err1;
    assign p0_rvalid = r_rvalid0;
    assign p1_rvalid = r_rvalid1;
    assign p0_rdata  = r_rdata0;
    assign p1_rdata  = r_rdata1;

    assign mem_ena   = (r_state == S_ISSUE);
    assign mem_store = r_store & mem_ena;
    assign mem_func3 = r_func3;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_sys_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_sys_arbiter
// Purpose  : Self-checking bench for mem_sys_arbiter. Contains a behavioural
//            memory system (sync-read byte RAM plus a combinational receiver),
//            a directed vector table, hand-written multi-cycle sequences and a
//            randomized phase scored against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_sys_arbiter;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_store, p1_req, p1_store;
    logic [2:0]        p0_func3, p1_func3;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [31:0]       p0_wdata, p1_wdata;
    logic              p0_ack, p0_rvalid, p0_err, p1_ack, p1_rvalid, p1_err;
    logic [31:0]       p0_rdata, p1_rdata;
    logic              mem_ena, mem_store;
    logic [2:0]        mem_func3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_load_data;

    always #5 clk = ~clk;

    mem_sys_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_store(p0_store), .p0_func3(p0_func3), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p0_err(p0_err),
        .p1_req(p1_req), .p1_store(p1_store), .p1_func3(p1_func3), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .p1_err(p1_err),
        .mem_ena(mem_ena), .mem_store(mem_store), .mem_func3(mem_func3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_load_data(mem_load_data)
    );

    // ---------------- behavioural memory system ----------------
    logic [7:0]  ram [64];
    logic [31:0] rd_word;
    logic [31:0] rx_sh;
    logic        env_clr;

    always @(posedge clk) begin
        if (env_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= 8'h00;
            rd_word <= 32'd0;
        end else if (mem_ena) begin
            if (mem_store) begin
                case (mem_func3[1:0])
                    2'b00: ram[mem_addr] <= mem_wdata[7:0];
                    2'b01: begin
                        ram[{mem_addr[5:1], 1'b0}] <= mem_wdata[7:0];
                        ram[{mem_addr[5:1], 1'b1}] <= mem_wdata[15:8];
                    end
                    default: begin
                        ram[{mem_addr[5:2], 2'd0}] <= mem_wdata[7:0];
                        ram[{mem_addr[5:2], 2'd1}] <= mem_wdata[15:8];
                        ram[{mem_addr[5:2], 2'd2}] <= mem_wdata[23:16];
                        ram[{mem_addr[5:2], 2'd3}] <= mem_wdata[31:24];
                    end
                endcase
            end else begin
                rd_word <= {ram[{mem_addr[5:2], 2'd3}], ram[{mem_addr[5:2], 2'd2}],
                            ram[{mem_addr[5:2], 2'd1}], ram[{mem_addr[5:2], 2'd0}]};
            end
        end
    end

    always_comb begin
        rx_sh = rd_word >> {mem_addr[1:0], 3'b000};
        case (mem_func3)
            3'b000:  mem_load_data = {{24{rx_sh[7]}}, rx_sh[7:0]};
            3'b001:  mem_load_data = {{16{rx_sh[15]}}, rx_sh[15:0]};
            3'b100:  mem_load_data = {24'd0, rx_sh[7:0]};
            3'b101:  mem_load_data = {16'd0, rx_sh[15:0]};
            default: mem_load_data = rd_word;
        endcase
    end

    // ---------------- reference model (byte-array level) ----------------
    logic [7:0] ref_mem [64];

    function automatic logic ref_legal(input logic st, input logic [2:0] f3, input int a);
        logic ok;
        int   sz;
        ok = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        sz = 1 << f3[1:0];
        return ok && ((a % sz) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int a);
        int          n;
        logic [31:0] v;
        n = 1 << f3[1:0];
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input int a, input logic [31:0] wd);
        int n;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
    endtask

    // ---------------- check bookkeeping ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic rq, input logic st, input logic [2:0] f3,
                            input logic [5:0] a, input logic [31:0] wd);
        if (p == 0) begin
            p0_req = rq; p0_store = st; p0_func3 = f3; p0_addr = a; p0_wdata = wd;
        end else begin
            p1_req = rq; p1_store = st; p1_func3 = f3; p1_addr = a; p1_wdata = wd;
        end
    endtask

    task automatic scramble(input int p);
        set_port(p, 1'b0, 1'($urandom), 3'($urandom), 6'($urandom), $urandom);
    endtask

    function automatic logic ack_of(input int p);    return (p == 0) ? p0_ack    : p1_ack;    endfunction
    function automatic logic err_of(input int p);    return (p == 0) ? p0_err    : p1_err;    endfunction
    function automatic logic rv_of(input int p);     return (p == 0) ? p0_rvalid : p1_rvalid; endfunction
    function automatic logic [31:0] rd_of(input int p); return (p == 0) ? p0_rdata : p1_rdata; endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack0"}, p0_ack, 0);       chk({tag, "_ack1"}, p1_ack, 0);
        chk({tag, "_rv0"}, p0_rvalid, 0);     chk({tag, "_rv1"}, p1_rvalid, 0);
        chk({tag, "_err0"}, p0_err, 0);       chk({tag, "_err1"}, p1_err, 0);
        chk({tag, "_ena"}, mem_ena, 0);       chk({tag, "_mst"}, mem_store, 0);
        chk({tag, "_mf3"}, mem_func3, 0);     chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_mwd"}, mem_wdata, 0);
        chk({tag, "_rd0"}, p0_rdata, 0);      chk({tag, "_rd1"}, p1_rdata, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          port;
        logic        st;
        logic [2:0]  f3;
        logic [5:0]  addr;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [16];

    // One request on an otherwise quiet bus; starts and ends 1 ns after a rising edge.
    task automatic run_vec(input vec_t v);
        set_port(v.port, 1'b1, v.st, v.f3, v.addr, v.wd);
        scramble(1 - v.port);
        @(negedge clk);
        chk("v_ack", ack_of(v.port), 1);
        chk("v_ack_other", ack_of(1 - v.port), 0);
        chk("v_ena_c0", mem_ena, 0);
        tick();
        scramble(v.port);
        @(negedge clk);
        if (v.exp_err) begin
            chk("v_err", err_of(v.port), 1);
            chk("v_err_noena", mem_ena, 0);
        end else begin
            chk("v_ena", mem_ena, 1);
            chk("v_mst", mem_store, v.st);
            chk("v_maddr", mem_addr, v.addr);
            chk("v_mf3", mem_func3, v.f3);
            chk("v_err_none", err_of(v.port), 0);
            if (v.st) begin
                chk("v_mwd", mem_wdata, v.wd);
                ref_store(v.f3, v.addr, v.wd);
            end else begin
                tick();
                scramble(0);
                scramble(1);
                @(negedge clk);
                chk("hold_ena", mem_ena, 0);
                chk("hold_mst", mem_store, 0);
                chk("hold_addr", mem_addr, v.addr);
                chk("hold_f3", mem_func3, v.f3);
                tick();
                @(negedge clk);
                chk("v_rvalid", rv_of(v.port), 1);
                chk("v_rvalid_other", rv_of(1 - v.port), 0);
                chk("v_rdata", rd_of(v.port), v.exp_rd);
            end
        end
        tick();
    endtask

    // ---------------- randomized-phase model state ----------------
    logic        pend [2];
    logic        pst  [2];
    logic [2:0]  pf3  [2];
    logic [5:0]  pad  [2];
    logic [31:0] pwd  [2];
    logic        s_err [8][2];
    logic        s_rv  [8][2];
    logic [31:0] s_rd  [8][2];
    logic        s_ena [8];
    logic [5:0]  s_addr[8];

    initial begin
        int pw, w, free_c, ptr_m, sl;

        env_clr = 1'b1;
        rst     = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
        set_port(0, 0, 0, 3'd0, 6'd0, 32'd0);
        set_port(1, 0, 0, 3'd0, 6'd0, 32'd0);
        tick();
        tick();
        @(negedge clk);
        check_reset_outputs("por");
        tick();
        env_clr = 1'b0;
        rst     = 1'b0;

        //              port st  f3      addr   wdata          err  rdata
        tbl[0]  = '{0, 1'b1, 3'b010, 6'h04, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{0, 1'b0, 3'b010, 6'h04, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{0, 1'b1, 3'b010, 6'h08, 32'h11223344, 1'b0, 32'h0};
        tbl[3]  = '{0, 1'b1, 3'b000, 6'h09, 32'h000000AA, 1'b0, 32'h0};
        tbl[4]  = '{0, 1'b0, 3'b100, 6'h09, 32'h0,        1'b0, 32'h000000AA};
        tbl[5]  = '{0, 1'b0, 3'b001, 6'h0A, 32'h0,        1'b0, 32'h00001122};
        tbl[6]  = '{0, 1'b1, 3'b000, 6'h09, 32'h00000080, 1'b0, 32'h0};
        tbl[7]  = '{0, 1'b0, 3'b000, 6'h09, 32'h0,        1'b0, 32'hFFFFFF80};
        tbl[8]  = '{1, 1'b0, 3'b010, 6'h06, 32'h0,        1'b1, 32'h0};
        tbl[9]  = '{1, 1'b1, 3'b001, 6'h03, 32'h1234,     1'b1, 32'h0};
        tbl[10] = '{1, 1'b0, 3'b011, 6'h00, 32'h0,        1'b1, 32'h0};
        tbl[11] = '{1, 1'b1, 3'b010, 6'h00, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[12] = '{1, 1'b0, 3'b101, 6'h02, 32'h0,        1'b0, 32'h0000CAFE};
        tbl[13] = '{1, 1'b0, 3'b001, 6'h02, 32'h0,        1'b0, 32'hFFFFCAFE};
        tbl[14] = '{1, 1'b0, 3'b100, 6'h03, 32'h0,        1'b0, 32'h000000CA};
        // Last grant goes to p0 and is rejected: the pointer must now name p1.
        tbl[15] = '{0, 1'b1, 3'b100, 6'h00, 32'h5A,       1'b1, 32'h0};
        for (int i = 0; i < 16; i++) run_vec(tbl[i]);

        // ---- contention: both hold load requests, grants must alternate ----
        set_port(0, 1'b1, 1'b0, 3'b010, 6'h04, 32'd0);
        set_port(1, 1'b1, 1'b0, 3'b010, 6'h08, 32'd0);
        w  = 1;
        pw = 0;
        for (int g = 0; g < 6; g++) begin
            @(negedge clk);
            chk("cont_ack_win", ack_of(w), 1);
            chk("cont_ack_lose", ack_of(1 - w), 0);
            if (g > 0) begin
                chk("cont_rv", rv_of(pw), 1);
                chk("cont_rv_other", rv_of(1 - pw), 0);
                chk("cont_rd", rd_of(pw), ref_load(3'b010, (pw == 0) ? 4 : 8));
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                chk("cont_idle_ack", {p1_ack, p0_ack}, 0);
                chk("cont_idle_rv", {p1_rvalid, p0_rvalid}, 0);
                tick();
            end
            pw = w;
            w  = 1 - w;
        end
        set_port(0, 1'b0, 1'b0, 3'b010, 6'h04, 32'd0);
        set_port(1, 1'b0, 1'b0, 3'b010, 6'h08, 32'd0);
        @(negedge clk);
        chk("cont_last_rv", rv_of(pw), 1);
        chk("cont_last_rd", rd_of(pw), ref_load(3'b010, (pw == 0) ? 4 : 8));
        tick();

        // ---- reset during the RESP cycle of a p0 load ----
        set_port(0, 1'b1, 1'b0, 3'b010, 6'h04, 32'd0);
        @(negedge clk);
        chk("rr_ack", p0_ack, 1);
        tick();
        set_port(0, 1'b0, 1'b0, 3'b010, 6'h04, 32'd0);
        @(negedge clk);
        chk("rr_ena", mem_ena, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rr");
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_no_rv", {p1_rvalid, p0_rvalid}, 0);
            chk("rr_no_ena", mem_ena, 0);
            tick();
        end
        set_port(0, 1'b1, 1'b0, 3'b010, 6'h04, 32'd0);
        set_port(1, 1'b1, 1'b0, 3'b010, 6'h08, 32'd0);
        @(negedge clk);
        chk("rr_first_ack0", p0_ack, 1);
        chk("rr_first_ack1", p1_ack, 0);
        tick();
        set_port(0, 1'b0, 1'b0, 3'b010, 6'h04, 32'd0);
        set_port(1, 1'b0, 1'b0, 3'b010, 6'h08, 32'd0);
        @(negedge clk);
        chk("rr_post_ena", mem_ena, 1);
        tick();
        tick();
        @(negedge clk);
        chk("rr_post_rv", p0_rvalid, 1);
        chk("rr_post_rd", p0_rdata, ref_load(3'b010, 4));
        tick();

        // ---- randomized phase: fresh reset so model pointer/free time are known ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int p = 0; p < 2; p++) pend[p] = 1'b0;
        for (int s = 0; s < 8; s++) begin
            s_ena[s] = 1'b0; s_addr[s] = 6'd0;
            for (int p = 0; p < 2; p++) begin
                s_err[s][p] = 1'b0; s_rv[s][p] = 1'b0; s_rd[s][p] = 32'd0;
            end
        end
        free_c = 0;
        ptr_m  = 0;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    pst[p]  = 1'($urandom);
                    pf3[p]  = 3'($urandom);
                    pad[p]  = 6'($urandom);
                    pwd[p]  = $urandom;
                end
                if (pend[p]) set_port(p, 1'b1, pst[p], pf3[p], pad[p], pwd[p]);
                else         scramble(p);
            end
            @(negedge clk);
            w = -1;
            if (c >= free_c) begin
                if (pend[0] && pend[1]) w = ptr_m;
                else if (pend[0])       w = 0;
                else if (pend[1])       w = 1;
            end
            chk("rnd_ack0", p0_ack, (w == 0));
            chk("rnd_ack1", p1_ack, (w == 1));
            if (w >= 0) begin
                ptr_m   = 1 - w;
                pend[w] = 1'b0;
                if (!ref_legal(pst[w], pf3[w], pad[w])) begin
                    s_err[(c + 1) % 8][w] = 1'b1;
                    free_c = c + 1;
                end else begin
                    s_ena[(c + 1) % 8]  = 1'b1;
                    s_addr[(c + 1) % 8] = pad[w];
                    if (pst[w]) begin
                        ref_store(pf3[w], pad[w], pwd[w]);
                        free_c = c + 2;
                    end else begin
                        s_rv[(c + 3) % 8][w] = 1'b1;
                        s_rd[(c + 3) % 8][w] = ref_load(pf3[w], pad[w]);
                        free_c = c + 3;
                    end
                end
            end
            sl = c % 8;
            chk("rnd_err", {p1_err, p0_err}, {s_err[sl][1], s_err[sl][0]});
            chk("rnd_rv", {p1_rvalid, p0_rvalid}, {s_rv[sl][1], s_rv[sl][0]});
            chk("rnd_ena", mem_ena, s_ena[sl]);
            if (s_ena[sl]) chk("rnd_maddr", mem_addr, s_addr[sl]);
            if (s_rv[sl][0]) chk("rnd_rd0", p0_rdata, s_rd[sl][0]);
            if (s_rv[sl][1]) chk("rnd_rd1", p1_rdata, s_rd[sl][1]);
            s_ena[sl] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                s_err[sl][p] = 1'b0;
                s_rv[sl][p]  = 1'b0;
            end
            tick();
        end
        scramble(0);
        scramble(1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_sys_arbiter.md
# mem_sys_arbiter

Two-port arbiter and sequencer in front of the byte-write memory system: the top-level memory wrapper, made up of the transmitter, the byte-write RAM and the receiver. It accepts load/store requests from two requesters and grants them round-robin. It checks func3 legality and alignment, then drives the memory system's single port for one access at a time. It holds address and func3 stable through the synchronous-read cycle, so the combinational receiver produces a correct load word, and registers that word back to the winning requester.

## Interface
- ADDR_W, 6, memory address width (byte address; bits [1:0] select byte lane)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- p0_req  in  1  port 0 request; held with payload stable until p0_ack
- p0_store  in  1  1 = store, 0 = load
- p0_func3  in  3  RISC-V func3 (width/sign)
- p0_addr  in  ADDR_W  byte address
- p0_wdata  in  32  store data, right-aligned
- p0_ack  out  1  one-cycle pulse: request accepted
- p0_rvalid  out  1  one-cycle pulse: load data valid
- p0_rdata  out  32  load result, held until next p0_rvalid
- p0_err  out  1  one-cycle pulse: request rejected, no memory access
- p1_req, p1_store, p1_func3, p1_addr, p1_wdata, p1_ack, p1_rvalid, p1_rdata, p1_err: same as port 0
- mem_ena  out  1  memory-system enable; high for exactly the ISSUE cycle
- mem_store  out  1  write qualifier; the integrating level must gate the write mask with it
- mem_func3  out  3  to memory-system func3
- mem_addr  out  ADDR_W  to memory-system address
- mem_wdata  out  32  to memory-system store data
- mem_load_data  in  32  receiver output (already extended and lane-shifted)

## Operation
- FSM: IDLE, ISSUE, RESP. Reset → IDLE.
- IDLE: arbitrate among asserted requests. If exactly one port requests, grant it. If both request, grant the port the round-robin pointer names.
  - After every grant, legal or rejected, the pointer moves to the other port. The reset pointer is port 0.
- On grant: pulse ack for that port in the same cycle and latch store, func3, addr and wdata into the access registers.
- Legality:
  - Legal load func3: 000, 001, 010, 100, 101.
  - Legal store func3: 000, 001, 010.
  - Halfword (func3[1:0]=01) requires addr[0]=0.
  - Word (func3[1:0]=10) requires addr[1:0]=00.
- Illegal or misaligned grant: ack is still given, the FSM stays in IDLE, and the port's err pulses in the next cycle. No mem_ena and no rvalid are generated.
- Legal grant: IDLE → ISSUE.
- ISSUE: mem_ena=1, mem_store=latched store. A store then goes to IDLE. A load goes to RESP.
- RESP: mem_ena=0. mem_func3 and mem_addr are held. mem_load_data is captured into the winning port's rdata at the end of the cycle, and that port's rvalid pulses in the next cycle. The FSM then goes to IDLE.
- mem_func3, mem_addr, mem_wdata and mem_store always reflect the access registers. These change only on a legal grant; mem_store is 0 outside ISSUE.
- A requester deasserting req before ack is a protocol violation. Behaviour in that case is unspecified but must not hang the FSM.

## Timing
- Reset values: all ack, rvalid and err outputs = 0; mem_ena = 0; mem_store = 0; mem_func3, mem_addr, mem_wdata = 0; p0_rdata and p1_rdata = 0; pointer = port 0.
- Reset mid-access: the access is abandoned immediately, no pending rvalid or err is delivered, and no further mem_ena is issued.
- Load with request in cycle 0:
  - cycle 0: ack
  - cycle 1: ISSUE, mem_ena=1
  - cycle 2: RESP
  - cycle 3: rvalid and rdata valid; the FSM is back in IDLE and may grant again in cycle 3.
- Store with request in cycle 0: ack in cycle 0, mem_ena in cycle 1, next grant possible in cycle 2.
- Throughput: one store per 2 cycles, one load per 3 cycles.
- Error: ack in cycle n, err in cycle n+1, next grant possible in cycle n+1.
- ack, rvalid and err are registered (for err, rvalid) or decoded from registered state plus req (for ack). No output is combinational from mem_load_data.

## Test plan
- Reset, then p0 stores SW 0xDEADBEEF at addr 0x04, then loads LW from 0x04 → p0_ack in cycles 0 and 2, mem_ena high in cycles 1 and 3, p0_rvalid in cycle 5 with p0_rdata=0xDEADBEEF.
- Byte/half lanes: SW 0x11223344 @0x08, then SB 0xAA @0x09, then LBU @0x09 → 0x000000AA; LH @0x0A → 0x00001122; LB @0x09 after SB 0x80 → 0xFFFFFF80.
- Contention: p0 and p1 hold req continuously with loads → grants alternate p0, p1, p0, …; each rvalid arrives on the correct port only, 3 cycles after its ack.
- Errors: p1 LW @0x06, then SH @0x03, then func3=011 → each gets p1_ack then p1_err next cycle; mem_ena never asserts; the pointer still toggles.
- Reset asserted in the RESP cycle of a p0 load → no p0_rvalid afterward; all outputs at reset values; the first request after reset is granted normally.
- Hold check: during RESP of LHU @0x02, mem_addr=0x02 and mem_func3=101 are unchanged from ISSUE, even when p1 changes its payload in that cycle.
